if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register.
//  Holds the fetch PC, issues pipelined requests to instruction memory, buffers
//  returned words with their PC in an in-order queue, and presents them to IF/ID.
//  Handles stall (IF/ID not enabled) and branch/jump redirect, discarding stale fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address after reset
//  DEPTH     4              queue entries = max (outstanding + buffered); power of 2, >=2
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  stall        in   1   1 = IF/ID not loading this cycle (its en_reg low)
//  redirect     in   1   1 = branch/jump taken, refetch from redirect_pc
//  redirect_pc  in   32  redirect target; bits [1:0] forced to 0
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address (word aligned)
//  imem_gnt     in   1   request accepted this cycle (req & gnt = accept)
//  imem_rvalid  in   1   read data valid; responses return in request order
//  imem_rdata   in   32  instruction word
//  instr_valid  out  1   instr/pc hold a valid fetched instruction
//  instr        out  32  instruction to IF/ID instr_in; 32'h0 when !instr_valid
//  pc           out  32  PC of instr, to IF/ID pc_in; 32'h0 when !instr_valid
// BEHAVIOUR
//  Reset (async, immediate): state=BOOT, fetch_pc=RESET_PC, queue empty,
//   outstanding=0, drop_cnt=0; imem_req=0, imem_addr=RESET_PC, instr_valid=0,
//   instr=0, pc=0. imem is reset by the same rst; no pre-reset response returns.
//  FSM: BOOT -> RUN next cycle unconditionally (no request in BOOT).
//   RUN -> DRAIN on redirect when stale in-flight count (outstanding, plus an
//   accept in the same cycle, minus an rvalid in the same cycle) > 0; else stay RUN.
//   DRAIN -> RUN when final stale response arrives (drop_cnt==1 & imem_rvalid)
//   with no redirect that cycle. Redirect in DRAIN: reload fetch_pc, add stale count, stay DRAIN.
//  Issue: imem_req = (state==RUN) & (outstanding + occupancy < DEPTH), using
//   registered counts only; imem_addr = fetch_pc. On accept: fetch_pc += 4
//   (mod 2^32, 32'hFFFF_FFFC -> 0), outstanding++. imem_req may drop without gnt.
//  Response: in RUN, imem_rvalid pushes {rdata, pc} (pc = issue address, tracked
//   per entry), outstanding--. In DRAIN, rvalid decrements drop_cnt, nothing pushed.
//  Output: head of queue, registered; instr_valid = !empty. Pop when
//   instr_valid & !stall & !redirect. Push visible at output next cycle.
//  Latency: accept at N, rvalid at N+1 -> instr_valid at N+2. With 1-cycle memory
//   and gnt=1 sustained throughput is 1 instr/cycle.
//  Redirect (priority over stall, pop, push): queue flushed, instr_valid=0 next
//   cycle, fetch_pc <= {redirect_pc[31:2],2'b00}; no request issued in the redirect
//   cycle's successor until state is RUN. Same-cycle accept counts as stale.
//  Stall: queue holds; issuing continues until credit exhausted; no data loss.
//  Counters never exceed DEPTH; rvalid with outstanding==0 and drop_cnt==0 is illegal (assert).
// TESTING
//  1 Reset, gnt=1, 1-cycle mem, no stall -> addr 0,4,8.. from cycle 2; instr_valid
//    from cycle 4, pc 0,4,8 consecutive, one per cycle.
//  2 stall held 10 cycles in steady stream -> imem_req drops once outstanding+occ=4;
//    instr/pc frozen; on release words resume in order, none lost or duplicated.
//  3 redirect to 32'h0000_0103 with 1 outstanding -> next fetch addr 32'h100;
//    stale response dropped; first valid pc = 32'h100; no old pc ever appears.
//  4 redirect with simultaneous stall and accept -> flush wins, DRAIN waits 2
//    stale responses, then RUN from target.
//  5 RESET_PC=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  6 rst asserted mid-stream with 3 queued -> outputs zero same cycle; restart from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: owns the fetch PC,
// issues pipelined imem requests within a credit limit, queues returned
// words with their PC in order, and discards responses made stale by a
// branch/jump redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];
    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    resp_pc_q, resp_pc_d;   // PC of the next non-stale response
    logic [CW-1:0]  out_q, out_d;           // live requests awaiting a response
    logic [CW-1:0]  drop_q, drop_d;         // stale responses still to discard
    logic [CW-1:0]  cnt_q, cnt_d;           // queue occupancy
    logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [31:0]    q_instr [DEPTH];
    logic [31:0]    q_pc    [DEPTH];

    logic [CW:0]    credit_sum;
    logic [CW-1:0]  stale, drop_base;
    logic           accept, rv_run, rv_drain, push, pop;
    logic           unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Credit uses registered counts only, so imem_req never depends on inputs.
    assign credit_sum = {1'b0, out_q} + {1'b0, cnt_q};
    assign imem_req   = (state_q == ST_RUN) && (credit_sum < DEPTH_W);
    assign imem_addr  = fetch_pc_q;

    assign accept   = imem_req & imem_gnt;
    assign rv_run   = imem_rvalid & (state_q == ST_RUN);
    assign rv_drain = imem_rvalid & (state_q == ST_DRAIN);
    assign push     = rv_run & ~redirect;
    assign pop      = instr_valid & ~stall & ~redirect;

    // Requests in flight after this cycle; all of them become stale on a redirect.
    assign stale     = out_q + CW'(accept) - CW'(rv_run);
    assign drop_base = drop_q - CW'(rv_drain);

    // Next-state logic for the FSM, fetch PC and in-flight bookkeeping.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = stale;
        drop_d     = drop_base;

        if (accept)  fetch_pc_d = fetch_pc_q + 32'd4;
        if (rv_run)  resp_pc_d  = resp_pc_q + 32'd4;

        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_DRAIN: if (drop_base == '0) state_d = ST_RUN;
            default:  state_d = ST_BOOT;
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            drop_d     = drop_base + stale;
            out_d      = '0;
            state_d    = ((drop_base + stale) != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    // Queue pointer/occupancy update; a redirect flushes the queue.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (redirect) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Control state registers with asynchronous reset.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= BOOT_PC;
            resp_pc_q  <= BOOT_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // Queue storage: write the returned word with the PC it was fetched from.
    // NOTE: storage is not reset; cnt_q gates every read, so contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_q] <= imem_rdata;
            q_pc[wr_q]    <= resp_pc_q;
        end
    end

    assign instr_valid = (cnt_q != '0);
    assign instr       = instr_valid ? q_instr[rd_q] : 32'h0;
    assign pc          = instr_valid ? q_pc[rd_q]    : 32'h0;

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> ((out_q != '0) || (drop_q != '0)));

    a_counts_bounded: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, out_q} <= DEPTH_W) && ({1'b0, drop_q} <= DEPTH_W) && ({1'b0, cnt_q} <= DEPTH_W));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle-by-cycle vector tables with
// hand-computed request/address/output expectations, a 1- or 2-cycle
// instruction memory, a second instance booting near the top of the
// address space, and an asynchronous reset in the middle of a stream.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr, pc;

    // second instance: wrap-around boot address, free-running 1-cycle memory
    logic        req2, rvalid2 = 1'b0, v2;
    logic [31:0] addr2, rdata2 = 32'h0, instr2, pc2;

    int n_checks = 0;
    int n_pass   = 0;

    // memory model pipeline: slot 1 answers this cycle, slot 2 the next
    int          mem_lat = 1;
    logic        p1_v = 1'b0, p2_v = 1'b0;
    logic [31:0] p1_a = 32'h0, p2_a = 32'h0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        chk2;
        logic [31:0] pc2;
    } vec_t;

    vec_t tbl[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
        .imem_gnt(1'b1), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .instr_valid(v2), .instr(instr2), .pc(pc2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic g, input logic rq, input logic [31:0] a,
                               input logic vl, input logic [31:0] p);
        vec_t r;
        r.stall = st; r.redir = rd; r.rpc = rpc; r.gnt = g;
        r.req = rq; r.addr = a; r.valid = vl; r.pc = p;
        r.chk2 = 1'b0; r.pc2 = 32'h0;
        return r;
    endfunction

    // One memory cycle: present the due response, then record this cycle's accept.
    task automatic mem_step();
        logic acc;
        imem_rvalid = p1_v;
        imem_rdata  = p1_v ? mem_word(p1_a) : 32'h0;
        acc = imem_req & imem_gnt;
        if (mem_lat == 1) begin
            p1_v = acc; p1_a = imem_addr;
        end else begin
            p1_v = p2_v; p1_a = p2_a;
            p2_v = acc;  p2_a = imem_addr;
        end
    endtask

    // Hold reset across two falling edges and release on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        p1_v = 1'b0; p2_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag, input int nrows);
        for (int i = 0; i < nrows; i++) begin
            check($sformatf("%s[%0d].req", tag, i),   {31'h0, imem_req},    {31'h0, tbl[i].req});
            check($sformatf("%s[%0d].addr", tag, i),  imem_addr,            tbl[i].addr);
            check($sformatf("%s[%0d].valid", tag, i), {31'h0, instr_valid}, {31'h0, tbl[i].valid});
            check($sformatf("%s[%0d].pc", tag, i),    pc,                   tbl[i].valid ? tbl[i].pc : 32'h0);
            check($sformatf("%s[%0d].instr", tag, i), instr,
                  tbl[i].valid ? mem_word(tbl[i].pc) : 32'h0);
            if (tbl[i].chk2) begin
                check($sformatf("%s[%0d].wrap_valid", tag, i), {31'h0, v2}, 32'h1);
                check($sformatf("%s[%0d].wrap_pc", tag, i), pc2, tbl[i].pc2);
            end
            stall       = tbl[i].stall;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            imem_gnt    = tbl[i].gnt;
            mem_step();
            @(negedge clk);
        end
        stall = 1'b0; redirect = 1'b0;
    endtask

    // Cold start, stall back-pressure, redirect with one request in flight.
    task automatic load_table_a();
        tbl.delete();
        tbl.push_back(v(0, 0, 0, 1, 0, 32'h00, 0, 32'h0));   // W0 BOOT
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h04, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h08, 1, 32'h00));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h0C, 1, 32'h04));
        tbl.push_back(v(1, 0, 0, 1, 1, 32'h10, 1, 32'h08));  // W5 stall begins
        tbl.push_back(v(1, 0, 0, 1, 1, 32'h14, 1, 32'h08));
        for (int i = 7; i < 15; i++)
            tbl.push_back(v(i < 15, 0, 0, 1, 0, 32'h18, 1, 32'h08));
        tbl.push_back(v(0, 0, 0, 1, 0, 32'h18, 1, 32'h08));  // W15 release
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h18, 1, 32'h0C));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h1C, 1, 32'h10));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h20, 1, 32'h14));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h24, 1, 32'h18));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h28, 1, 32'h1C));
        tbl.push_back(v(0, 1, 32'h0000_0103, 0, 1, 32'h2C, 1, 32'h20)); // W21 redirect
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h100, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h104, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h108, 1, 32'h100));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h10C, 1, 32'h104));
        tbl[3].chk2 = 1'b1; tbl[3].pc2 = 32'hFFFF_FFF8;
        tbl[4].chk2 = 1'b1; tbl[4].pc2 = 32'hFFFF_FFFC;
        tbl[5].chk2 = 1'b1; tbl[5].pc2 = 32'h0000_0000;
        tbl[6].chk2 = 1'b1; tbl[6].pc2 = 32'h0000_0004;
    endtask

    // 2-cycle memory: redirect together with stall and an accept -> two stale drops.
    task automatic load_table_b();
        tbl.delete();
        tbl.push_back(v(0, 0, 0, 1, 0, 32'h00, 0, 32'h0));   // W0 BOOT
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h04, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h08, 0, 32'h0));
        tbl.push_back(v(1, 1, 32'h0000_0200, 1, 1, 32'h0C, 1, 32'h0)); // W4
        tbl.push_back(v(0, 0, 0, 1, 0, 32'h200, 0, 32'h0));  // DRAIN, 2 left
        tbl.push_back(v(0, 0, 0, 1, 0, 32'h200, 0, 32'h0));  // DRAIN, 1 left
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h200, 0, 32'h0));  // RUN again
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h204, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h208, 0, 32'h0));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h20C, 1, 32'h200));
        tbl.push_back(v(0, 0, 0, 1, 1, 32'h210, 1, 32'h204));
        tbl.push_back(v(1, 0, 0, 1, 1, 32'h214, 1, 32'h208)); // W12 stall
        tbl.push_back(v(1, 0, 0, 1, 0, 32'h218, 1, 32'h208));
    endtask

    // Free-running memory for the wrap-around instance.
    initial begin
        logic        m2_v;
        logic [31:0] m2_a;
        m2_v = 1'b0; m2_a = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m2_v = 1'b0; rvalid2 = 1'b0;
            end else begin
                rvalid2 = m2_v;
                rdata2  = mem_word(m2_a);
                m2_v = req2; m2_a = addr2;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rst.req",   {31'h0, imem_req},    32'h0);
        check("rst.addr",  imem_addr,            32'h0);
        check("rst.valid", {31'h0, instr_valid}, 32'h0);
        check("rst.instr", instr,                32'h0);
        check("rst.pc",    pc,                   32'h0);
        check("rst.wrap_addr", addr2,            32'hFFFF_FFF8);

        mem_lat = 1;
        do_reset();
        load_table_a();
        run_table("A", tbl.size());

        mem_lat = 2;
        do_reset();
        load_table_b();
        run_table("B", tbl.size());

        // W14: three words queued under stall, then an asynchronous reset mid-cycle.
        check("mid.valid", {31'h0, instr_valid}, 32'h1);
        check("mid.pc",    pc,                   32'h208);
        check("mid.req",   {31'h0, imem_req},    32'h0);
        #2 rst = 1'b1;
        #1;
        check("async.valid", {31'h0, instr_valid}, 32'h0);
        check("async.instr", instr,                32'h0);
        check("async.pc",    pc,                   32'h0);
        check("async.req",   {31'h0, imem_req},    32'h0);
        check("async.addr",  imem_addr,            32'h0);

        mem_lat = 1;
        do_reset();
        load_table_a();
        run_table("C", 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
